// File: rtl/heap_array_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : heap_array_pkg
// Purpose  : Shared types for the heap array unit: request opcodes, FSM state
//            codes, width helpers and the packed response record.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package heap_array_pkg;

  typedef enum logic [2:0] {
    OP_ALLOC  = 3'd0,
    OP_FREE   = 3'd1,
    OP_WRITE  = 3'd2,
    OP_READ   = 3'd3,
    OP_SIZE   = 3'd4,
    OP_INSERT = 3'd5,
    OP_DELETE = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  // Widest data the response record can carry; resp_data is a slice of it.
  localparam int RESP_DW = 32;

  typedef struct packed {
    logic               valid;
    logic               error;
    logic [RESP_DW-1:0] data;
  } resp_t;

  // Array id width; never below one bit even for a single array.
  function automatic int aw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index/size width: must hold the value NAREA itself (a full array).
  function automatic int iw_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : heap_array_pkg
`default_nettype wire

// File: rtl/array_free_stack.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : array_free_stack
// Purpose  : LIFO of freed array ids. Pointer is reset, storage is not.
// Ports    : clock   - clock
//            reset   - asynchronous active-low reset of the pointer
//            push    - push push_id (caller never pushes when full)
//            push_id - id to push
//            pop     - discard the top entry (caller never pops when empty)
//            top_id  - current top entry, valid when !empty
//            empty   - stack holds no ids
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module array_free_stack #(
  parameter int DEPTH = 64,
  parameter int IDW   = 6
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  logic [IDW-1:0] push_id,
  input  logic           pop,
  output logic [IDW-1:0] top_id,
  output logic           empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int XW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]  r_ptr;
  logic [IDW-1:0] r_mem [DEPTH];
  logic [XW-1:0]  w_wr_idx;
  logic [XW-1:0]  w_top_idx;

  assign w_wr_idx  = r_ptr[XW-1:0];
  assign w_top_idx = XW'(r_ptr - 1'b1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + 1'b1;
    end else if (pop) begin
      r_ptr <= r_ptr - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      r_mem[w_wr_idx] <= push_id;
    end
  end

  assign top_id = r_mem[w_top_idx];
  assign empty  = (r_ptr == '0);

endmodule : array_free_stack
`default_nettype wire

// File: rtl/heap_array_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : heap_array_unit
// Purpose  : Heap array manager. Owns the heap, per-array sizes, the live
//            bitmap, the fresh-id high-water mark and the freed-id stack;
//            services one request at a time (alloc/free/write/read/size and
//            multi-cycle insert/delete shifts).
// Ports    : clock, reset (async active-low)
//            req_valid/req_ready - request handshake (ready only in IDLE)
//            req_op/req_array/req_index/req_wdata - request fields
//            resp_valid - one-cycle completion pulse
//            resp_data  - id / read value / size / deleted value
//            resp_error - request rejected, no state changed
//            allocs     - count of fresh ids ever issued
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module heap_array_unit
  import heap_array_pkg::*;
#(
  parameter  int WIDTH   = 12,
  parameter  int NARRAYS = 64,
  parameter  int NAREA   = 10,
  localparam int AW      = aw_of(NARRAYS),
  localparam int IW      = iw_of(NAREA)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [AW-1:0]    req_array,
  input  logic [IW-1:0]    req_index,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_error,
  output logic [AW:0]      allocs
);

  localparam int HDEPTH = NARRAYS * NAREA;
  localparam int HAW    = aw_of(HDEPTH);

  localparam logic [1:0]     c_st_idle  = ST_IDLE;
  localparam logic [1:0]     c_st_resp  = ST_RESP;
  localparam logic [1:0]     c_st_shift = ST_SHIFT;
  localparam logic [IW-1:0]  c_narea    = IW'(NAREA);
  localparam logic [HAW-1:0] c_narea_h  = HAW'(NAREA);
  localparam logic [AW:0]    c_narrays  = (AW + 1)'(NARRAYS);

  // Architectural state
  logic [1:0]         r_state;
  logic               r_ready_en;
  logic [NARRAYS-1:0] r_live;
  logic [IW-1:0]      r_size [NARRAYS];
  logic [AW:0]        r_allocs;
  resp_t              r_resp;
  logic [WIDTH-1:0]   r_heap [HDEPTH];

  // Context of the insert/delete in flight
  logic [AW-1:0]      r_arr;
  logic [HAW-1:0]     r_base;
  logic [IW-1:0]      r_index;
  logic [IW-1:0]      r_pos;   // source element of the next move
  logic [IW-1:0]      r_cnt;   // moves still to do
  logic               r_is_ins;
  logic [WIDTH-1:0]   r_val;   // insert value, or captured deleted value

  // Request decode
  logic               w_accept;
  logic               w_arr_ok;
  logic               w_live;
  logic [IW-1:0]      w_cur_size;
  logic [HAW-1:0]     w_base;
  logic [HAW-1:0]     w_addr;
  logic [WIDTH-1:0]   w_rd_req;
  logic [HAW-1:0]     w_sh_src;
  logic [WIDTH-1:0]   w_rd_sh;
  logic               w_err;
  logic               w_ok;

  // Free stack
  logic               w_stk_empty;
  logic [AW-1:0]      w_stk_top;
  logic               w_push;
  logic               w_pop;
  logic [AW-1:0]      w_alloc_id;

  // Heap write port
  logic               w_we;
  logic [HAW-1:0]     w_waddr;
  logic [WIDTH-1:0]   w_wdata;

  logic               w_unused_resp;

  assign req_ready  = r_ready_en && (r_state == c_st_idle);
  assign w_accept   = req_valid && req_ready;

  // Extra bit keeps the range test meaningful when NARRAYS is a power of two.
  assign w_arr_ok   = ({1'b0, req_array} < c_narrays);
  assign w_live     = w_arr_ok && r_live[req_array];
  assign w_cur_size = w_arr_ok ? r_size[req_array] : '0;

  // Address formed at heap-address width so array*NAREA+index never wraps.
  assign w_base     = HAW'(req_array) * c_narea_h;
  assign w_addr     = w_base + HAW'(req_index);
  assign w_rd_req   = r_heap[w_addr];
  assign w_sh_src   = r_base + HAW'(r_pos);
  assign w_rd_sh    = r_heap[w_sh_src];

  always_comb begin
    w_err = 1'b0;
    case (req_op)
      OP_ALLOC:  w_err = w_stk_empty && (r_allocs == c_narrays);
      OP_FREE:   w_err = !w_live;
      OP_WRITE,
      OP_READ:   w_err = !w_live || (req_index >= c_narea);
      OP_SIZE:   w_err = !w_live;
      OP_INSERT: w_err = !w_live || (w_cur_size == c_narea) || (req_index > w_cur_size);
      OP_DELETE: w_err = !w_live || (req_index >= w_cur_size);
      default:   w_err = 1'b1;
    endcase
  end

  assign w_ok       = w_accept && !w_err;
  assign w_push     = w_ok && (req_op == OP_FREE);
  assign w_pop      = w_ok && (req_op == OP_ALLOC) && !w_stk_empty;
  // Recycled ids take priority over fresh ones.
  assign w_alloc_id = w_stk_empty ? r_allocs[AW-1:0] : w_stk_top;

  array_free_stack #(
    .DEPTH (NARRAYS),
    .IDW   (AW)
  ) u_free_stack (
    .clock   (clock),
    .reset   (reset),
    .push    (w_push),
    .push_id (req_array),
    .pop     (w_pop),
    .top_id  (w_stk_top),
    .empty   (w_stk_empty)
  );

  // Single heap write port shared by WRITE, shift moves and the insert store.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_addr;
    w_wdata = req_wdata;
    if (r_state == c_st_idle) begin
      w_we = w_ok && (req_op == OP_WRITE);
    end else if (r_state == c_st_shift) begin
      if (r_cnt != '0) begin
        w_we    = 1'b1;
        w_wdata = w_rd_sh;
        // Insert walks down copying up; delete walks up copying down.
        w_waddr = r_is_ins ? (w_sh_src + 1'b1) : (w_sh_src - 1'b1);
      end else if (r_is_ins) begin
        w_we    = 1'b1;
        w_waddr = r_base + HAW'(r_index);
        w_wdata = r_val;
      end
    end
  end

  // Heap contents survive reset.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_heap[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= c_st_idle;
      r_ready_en <= 1'b0;
      r_live     <= '0;
      for (int i = 0; i < NARRAYS; i++) begin
        r_size[i] <= '0;
      end
      r_allocs   <= '0;
      r_resp     <= '0;
      r_arr      <= '0;
      r_base     <= '0;
      r_index    <= '0;
      r_pos      <= '0;
      r_cnt      <= '0;
      r_is_ins   <= 1'b0;
      r_val      <= '0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_state      <= c_st_resp;
            r_resp.valid <= 1'b1;
            r_resp.error <= w_err;
            r_resp.data  <= '0;
            if (!w_err) begin
              case (req_op)
                OP_ALLOC: begin
                  r_live[w_alloc_id] <= 1'b1;
                  r_size[w_alloc_id] <= '0;
                  if (w_stk_empty) begin
                    r_allocs <= r_allocs + 1'b1;
                  end
                  r_resp.data <= RESP_DW'(w_alloc_id);
                end
                OP_FREE: begin
                  r_live[req_array] <= 1'b0;
                end
                OP_WRITE: begin
                  if (req_index >= w_cur_size) begin
                    r_size[req_array] <= req_index + 1'b1;
                  end
                end
                OP_READ: begin
                  r_resp.data <= RESP_DW'(w_rd_req);
                end
                OP_SIZE: begin
                  r_resp.data <= RESP_DW'(w_cur_size);
                end
                OP_INSERT: begin
                  r_state      <= c_st_shift;
                  r_resp.valid <= 1'b0;
                  r_arr        <= req_array;
                  r_base       <= w_base;
                  r_index      <= req_index;
                  r_is_ins     <= 1'b1;
                  r_val        <= req_wdata;
                  r_cnt        <= w_cur_size - req_index;
                  r_pos        <= w_cur_size - 1'b1;
                end
                OP_DELETE: begin
                  r_state      <= c_st_shift;
                  r_resp.valid <= 1'b0;
                  r_arr        <= req_array;
                  r_base       <= w_base;
                  r_index      <= req_index;
                  r_is_ins     <= 1'b0;
                  r_val        <= w_rd_req;
                  r_cnt        <= w_cur_size - req_index - 1'b1;
                  r_pos        <= req_index + 1'b1;
                end
                default: begin
                end
              endcase
            end
          end
        end
        c_st_resp: begin
          r_resp  <= '0;
          r_state <= c_st_idle;
        end
        c_st_shift: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_pos <= r_is_ins ? (r_pos - 1'b1) : (r_pos + 1'b1);
          end else begin
            r_size[r_arr] <= r_is_ins ? (r_size[r_arr] + 1'b1) : (r_size[r_arr] - 1'b1);
            r_resp.valid  <= 1'b1;
            r_resp.error  <= 1'b0;
            r_resp.data   <= r_is_ins ? '0 : RESP_DW'(r_val);
            r_state       <= c_st_resp;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign resp_valid    = r_resp.valid;
  assign resp_error    = r_resp.error;
  assign resp_data     = r_resp.data[WIDTH-1:0];
  assign allocs        = r_allocs;
  assign w_unused_resp = |r_resp.data;

endmodule : heap_array_unit
`default_nettype wire

// File: doc/heap_array_unit.md
Name: heap_array_unit

Overview:
- Clocked heap-array manager for the zero VM FPGA flow. Replaces the per-program inline array/mov/free code with one reusable block.
- Owns the heap, per-array sizes, the allocation high-water mark and the freed-array stack.
- Services one request at a time: alloc, free, indexed write/read, size query, and multi-cycle insert/delete shifts within an array area.
- The instruction sequencer sits upstream and issues requests through a valid/ready handshake.

Parameters:
- WIDTH, 12, heap element and data width in bits.
- NARRAYS, 64, maximum number of concurrently live arrays.
- NAREA, 10, elements per array area; heap depth is NARRAYS*NAREA.
- AW, $clog2(NARRAYS), array id width (derived, not overridden).
- IW, $clog2(NAREA+1), index/size width (derived, not overridden).

Ports:
- clock  in  1  single clock for all state.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_op  in  3  0 ALLOC, 1 FREE, 2 WRITE, 3 READ, 4 SIZE, 5 INSERT, 6 DELETE, 7 reserved.
- req_array  in  AW  target array id.
- req_index  in  IW  element index.
- req_wdata  in  WIDTH  write/insert value.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  WIDTH  alloc id / read value / size / deleted value, zero-extended.
- resp_error  out  1  request rejected, state unchanged.
- allocs  out  AW+1  high-water count of fresh ids ever issued.

Behaviour:
- Reset is asynchronous on reset low. All outputs go to 0, including req_ready.
- Reset clears: sizes, live bitmap, freed-stack top, allocs, FSM state = IDLE.
- Reset does not clear heap contents.
- req_ready rises on the first clock edge after reset deasserts.
- FSM states: IDLE, RESP, SHIFT.
- A request is accepted when req_valid && req_ready; this only happens in IDLE. req_ready is low in RESP and SHIFT.
- Single-cycle ops (ALLOC, FREE, WRITE, READ, SIZE, and any error): accept edge -> RESP. resp_valid is high for exactly the cycle after acceptance, then back to IDLE. Latency is 1 cycle; the next request can be accepted 2 cycles after the previous one.
- ALLOC:
  - Freed stack non-empty: pop it (LIFO).
  - Otherwise: issue id = allocs and increment allocs.
  - Either way: size[id] = 0, mark live, resp_data = id.
  - Error if the stack is empty and allocs == NARRAYS.
- FREE: error if the array is not live. Otherwise clear live and push the id on the freed stack. The stack can never overflow.
- WRITE: error if not live or index >= NAREA. Otherwise heap[array*NAREA+index] = wdata and size = max(size, index+1).
- READ: error if not live or index >= NAREA. Otherwise resp_data = heap element; index >= size returns stale heap contents.
- SIZE: error if not live. Otherwise resp_data = size.
- INSERT:
  - Error if not live, size == NAREA, or index > size.
  - Otherwise go to SHIFT: move one element per cycle from position size-1 down to index, copying to position+1.
  - Then write wdata at index, size += 1, then RESP.
  - Total latency = (size-index)+2 cycles.
- DELETE:
  - Error if not live or index >= size.
  - Capture the element at index into resp_data.
  - Move positions index+1 .. size-1 down by one, one per cycle, then size -= 1, then RESP.
  - Latency = (size-index)+1 cycles.
- Arithmetic: heap address = array*NAREA + index computed at full width with no wrap. Sizes saturate at NAREA by the error checks.
- Simultaneous events: req_valid arriving while busy is held off by req_ready = 0. Requests are never queued.
- Reset asserted mid-SHIFT aborts the operation. Partially shifted heap data stays, but all arrays become not-live with size 0, so the data is unobservable.
- An error response leaves heap, sizes, stack, bitmap and allocs untouched.

Decomposition:
- Package heap_array_pkg holds:
  - the op enum (ALLOC..DELETE);
  - the state enum;
  - localparam functions for AW/IW;
  - a packed response struct {valid, error, data}.
- One sub-module: array_free_stack, a NARRAYS-deep LIFO of AW-bit ids with push, pop, empty outputs and async active-low reset of its pointer.

Test Plan:
- VM regression, run in order:
  - ALLOC -> 0;
  - WRITE(0,0,11), WRITE(0,1,22);
  - ALLOC -> 1;
  - WRITE(1,1,33);
  - READ(0,0) = 11, READ(0,1) = 22, READ(1,1) = 33;
  - SIZE(0) = 2, SIZE(1) = 2, allocs = 2.
- Recycling:
  - ALLOC x3 -> 0,1,2; FREE 1, FREE 2; ALLOC -> 2, ALLOC -> 1 (LIFO); ALLOC -> 3; allocs = 4.
  - FREE 1 twice -> second response has resp_error = 1.
- Insert/delete:
  - Array holds [5,6,7]. INSERT(idx 1, 9) -> [5,9,6,7], size 4, resp_valid 4 cycles after accept.
  - DELETE(idx 0) -> resp_data 5, array [9,6,7], size 3.
- Limits, each -> error with state unchanged:
  - Fill NAREA = 10 elements, then INSERT.
  - WRITE at index 10.
  - READ of an array that was never allocated.
  - 65th ALLOC with NARRAYS = 64.
- Handshake: hold req_valid high continuously. Verify req_ready is low in RESP/SHIFT, each request is accepted exactly once, and no request is dropped.
- Reset mid-SHIFT: pull reset low during INSERT. Outputs go to 0 immediately. After release, SIZE(0) errors and ALLOC returns 0.
